imem_loader: RTL and testbench

Boot-time program loader placed in front of `top`'s flash port. It accepts a byte stream over a ready/valid handshake (UART receiver or bench driver), packs the bytes little-endian into WIDTH-bit instructions and drives `flash_addr`/`flash_data`/`flash_en` one word at a time at auto-incrementing byte addresses. It holds the core in reset until the whole image has arrived and its checksum verifies. It replaces hand-sequenced `flash()` pulses with a length-framed, checksummed, parametrised load.

---
 rtl/imem_loader_if.sv | 22 ++
 rtl/imem_loader.sv | 142 ++++++++++++++
 tb/tb_imem_loader.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Byte-stream handshake and instruction-memory write port of the boot loader.
// master = stream source / memory side, slave = the loader itself.
interface imem_loader_if #(
    parameter int WIDTH = 32
);
    logic [7:0]       in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] flash_addr;
    logic [WIDTH-1:0] flash_data;
    logic             flash_en;

    modport master (
        output in_data, in_valid,
        input  in_ready, flash_addr, flash_data, flash_en
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, flash_addr, flash_data, flash_en
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: length-framed, checksummed byte stream packed little-endian into
// instruction words and written to flash; holds the core in reset until verified.
//
//   state | meaning
//   LEN0  | waiting for word-count low byte
//   LEN1  | waiting for word-count high byte
//   DATA  | packing data bytes into the current word
//   WRITE | one-cycle flash write strobe, no byte accepted
//   CHECK | waiting for checksum byte
//   DONE  | image verified, core released
//   ERROR | oversize image or bad checksum, core held
module imem_loader #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 512
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       restart,
    imem_loader_if.slave               bus,
    output logic                       core_rst,
    output logic                       done,
    output logic                       error,
    output logic [$clog2(DEPTH+1)-1:0] words_written
);
    localparam int BPW = WIDTH / 8;
    localparam int BSH = $clog2(BPW);
    localparam int BCW = (BSH > 0) ? BSH : 1;
    localparam int CW  = $clog2(DEPTH + 1);
    localparam logic [BCW-1:0] LAST_BYTE = BCW'(BPW - 1);

    localparam logic [2:0] S_LEN0  = 3'd0;
    localparam logic [2:0] S_LEN1  = 3'd1;
    localparam logic [2:0] S_DATA  = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_CHECK = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_ERROR = 3'd6;

    logic [2:0]       state_q, state_d;
    logic [7:0]       len_lo_q, len_lo_d;
    logic [15:0]      len_q, len_d;
    logic [CW-1:0]    idx_q, idx_d;
    logic [BCW-1:0]   bcnt_q, bcnt_d;
    // Holds bytes 0..BPW-2; the final byte goes straight into the write word.
    logic [WIDTH-9:0] pack_q, pack_d;
    logic [7:0]       sum_q, sum_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] data_q, data_d;

    logic        ready_w;
    logic        take;
    logic [15:0] len_w;

    assign ready_w = !rst && (state_q == S_LEN0 || state_q == S_LEN1 ||
                              state_q == S_DATA || state_q == S_CHECK);
    assign take    = ready_w && bus.in_valid;
    assign len_w   = {bus.in_data, len_lo_q};

    always_comb begin
        state_d  = state_q;
        len_lo_d = len_lo_q;
        len_d    = len_q;
        idx_d    = idx_q;
        bcnt_d   = bcnt_q;
        pack_d   = pack_q;
        sum_d    = sum_q;
        addr_d   = addr_q;
        data_d   = data_q;
        if (restart) begin
            state_d = S_LEN0;
            idx_d   = '0;
            bcnt_d  = '0;
            sum_d   = '0;
        end else begin
            case (state_q)
                S_LEN0: if (take) begin
                    len_lo_d = bus.in_data;
                    state_d  = S_LEN1;
                end
                S_LEN1: if (take) begin
                    len_d = len_w;
                    if (len_w > 16'(DEPTH))   state_d = S_ERROR;
                    else if (len_w == 16'd0)  state_d = S_CHECK;
                    else                      state_d = S_DATA;
                end
                S_DATA: if (take) begin
                    sum_d = sum_q + bus.in_data;
                    if (bcnt_q == LAST_BYTE) begin
                        bcnt_d  = '0;
                        data_d  = {bus.in_data, pack_q};
                        addr_d  = WIDTH'(idx_q) << BSH;
                        idx_d   = idx_q + CW'(1);
                        state_d = S_WRITE;
                    end else begin
                        pack_d[8*bcnt_q +: 8] = bus.in_data;
                        bcnt_d = bcnt_q + BCW'(1);
                    end
                end
                S_WRITE: state_d = (16'(idx_q) == len_q) ? S_CHECK : S_DATA;
                S_CHECK: if (take) begin
                    state_d = (bus.in_data == sum_q) ? S_DONE : S_ERROR;
                end
                S_DONE:  state_d = S_DONE;
                S_ERROR: state_d = S_ERROR;
                default: state_d = S_LEN0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_LEN0;
            len_lo_q <= '0;
            len_q    <= '0;
            idx_q    <= '0;
            bcnt_q   <= '0;
            pack_q   <= '0;
            sum_q    <= '0;
            addr_q   <= '0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            len_lo_q <= len_lo_d;
            len_q    <= len_d;
            idx_q    <= idx_d;
            bcnt_q   <= bcnt_d;
            pack_q   <= pack_d;
            sum_q    <= sum_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
        end
    end

    assign bus.in_ready   = ready_w;
    assign bus.flash_en   = (state_q == S_WRITE);
    assign bus.flash_addr = addr_q;
    assign bus.flash_data = data_q;
    assign core_rst       = (state_q != S_DONE);
    assign done           = (state_q == S_DONE);
    assign error          = (state_q == S_ERROR);
    assign words_written  = idx_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of framed images plus hand sequences
// for reset, write latency, oversize timing, full-depth image and aborts.
module tb_imem_loader;
    logic       clk;
    logic       rst;
    logic       restart;
    logic       core_rst;
    logic       done;
    logic       error;
    logic [9:0] words_written;

    imem_loader_if #(.WIDTH(32)) bus ();

    imem_loader #(.WIDTH(32), .DEPTH(512)) dut (
        .clk           (clk),
        .rst           (rst),
        .restart       (restart),
        .bus           (bus),
        .core_rst      (core_rst),
        .done          (done),
        .error         (error),
        .words_written (words_written)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] mon_addr[$];
    logic [31:0] mon_data[$];
    always @(negedge clk) begin
        if (bus.flash_en) begin
            mon_addr.push_back(bus.flash_addr);
            mon_data.push_back(bus.flash_data);
        end
    end

    typedef struct {
        string        name;
        int           nb;
        logic [127:0] bytes;
        bit           gap;
        int           nwr;
        logic [95:0]  wa;
        logic [95:0]  wd;
        logic         ed;
        logic         ee;
        int           eww;
    } vec_t;

    vec_t vt[6];
    int checks;
    int errors;

    localparam logic [127:0] JUMP_OK  = 128'h00ab_ffdf_f06f_0016_0613_00c6_4633_0003;
    localparam logic [127:0] JUMP_BAD = 128'h00ac_ffdf_f06f_0016_0613_00c6_4633_0003;
    localparam logic [95:0]  JUMP_WA  = {32'h8, 32'h4, 32'h0};
    localparam logic [95:0]  JUMP_WD  = {32'hffdff06f, 32'h00160613, 32'h00c64633};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entered at a negedge; returns at the negedge after the accepting edge.
    task automatic send_byte(input logic [7:0] b, input int gap);
        int n;
        if (gap > 0) begin
            bus.in_valid = 1'b0;
            repeat (gap) @(negedge clk);
        end
        bus.in_data  = b;
        bus.in_valid = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: byte %h never accepted", b);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_restart();
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
    endtask

    task automatic send_jump();
        logic [127:0] v;
        v = JUMP_OK;
        for (int i = 0; i < 15; i++) send_byte(v[8*i +: 8], 0);
    endtask

    task automatic expect_jump_writes(input string nm, input int base);
        chk({nm, "_nwr"}, 32'(mon_addr.size() - base), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (base + i < mon_addr.size()) begin
                chk({nm, "_addr"}, mon_addr[base+i], JUMP_WA[32*i +: 32]);
                chk({nm, "_data"}, mon_data[base+i], JUMP_WD[32*i +: 32]);
            end
        end
        chk({nm, "_done"}, 32'(done), 32'd1);
        chk({nm, "_core_rst"}, 32'(core_rst), 32'd0);
        chk({nm, "_ww"}, 32'(words_written), 32'd3);
    endtask

    initial begin
        int base;
        int gap;
        checks = 0;
        errors = 0;

        vt[0] = '{"jump", 15, JUMP_OK, 1'b0, 3, JUMP_WA, JUMP_WD, 1'b1, 1'b0, 3};
        vt[1] = '{"badchk", 15, JUMP_BAD, 1'b0, 3, JUMP_WA, JUMP_WD, 1'b0, 1'b1, 3};
        vt[2] = '{"empty", 3, 128'h000000, 1'b0, 0, 96'h0, 96'h0, 1'b1, 1'b0, 0};
        vt[3] = '{"oversize", 2, 128'h0201, 1'b0, 0, 96'h0, 96'h0, 1'b0, 1'b1, 0};
        vt[4] = '{"single", 7, 128'h14_12345678_0001, 1'b0, 1, 96'h0, 96'h12345678, 1'b1, 1'b0, 1};
        vt[5] = '{"backpressure", 15, JUMP_OK, 1'b1, 3, JUMP_WA, JUMP_WD, 1'b1, 1'b0, 3};

        rst          = 1'b1;
        restart      = 1'b0;
        bus.in_data  = 8'h00;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_flash_en", 32'(bus.flash_en), 32'd0);
        chk("rst_flash_addr", bus.flash_addr, 32'd0);
        chk("rst_flash_data", bus.flash_data, 32'd0);
        chk("rst_core_rst", 32'(core_rst), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_error", 32'(error), 32'd0);
        chk("rst_ww", 32'(words_written), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);

        for (int v = 0; v < 6; v++) begin
            pulse_restart();
            chk({vt[v].name, "_restart_ww"}, 32'(words_written), 32'd0);
            base = mon_addr.size();
            for (int i = 0; i < vt[v].nb; i++) begin
                // Gapped mode: idle cycles between bytes, except the first byte
                // of each later word, which is offered while WRITE is in progress.
                gap = (vt[v].gap && !(i >= 6 && (i - 2) % 4 == 0)) ? 2 : 0;
                send_byte(vt[v].bytes[8*i +: 8], gap);
            end
            repeat (3) @(negedge clk);
            chk({vt[v].name, "_nwr"}, 32'(mon_addr.size() - base), 32'(vt[v].nwr));
            for (int w = 0; w < vt[v].nwr; w++) begin
                if (base + w < mon_addr.size()) begin
                    chk({vt[v].name, "_addr"}, mon_addr[base+w], vt[v].wa[32*w +: 32]);
                    chk({vt[v].name, "_data"}, mon_data[base+w], vt[v].wd[32*w +: 32]);
                end
            end
            chk({vt[v].name, "_done"}, 32'(done), 32'(vt[v].ed));
            chk({vt[v].name, "_error"}, 32'(error), 32'(vt[v].ee));
            chk({vt[v].name, "_core_rst"}, 32'(core_rst), 32'(!vt[v].ed));
            chk({vt[v].name, "_ww"}, 32'(words_written), 32'(vt[v].eww));
            chk({vt[v].name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        end

        // Write latency and hold of address/data after the strobe.
        pulse_restart();
        send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        send_byte(8'h78, 0);
        send_byte(8'h56, 0);
        send_byte(8'h34, 0);
        chk("lat_no_early_en", 32'(bus.flash_en), 32'd0);
        send_byte(8'h12, 0);
        chk("lat_en", 32'(bus.flash_en), 32'd1);
        chk("lat_addr", bus.flash_addr, 32'h0);
        chk("lat_data", bus.flash_data, 32'h12345678);
        chk("lat_ww", 32'(words_written), 32'd1);
        chk("lat_ready_in_write", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        chk("lat_en_one_cycle", 32'(bus.flash_en), 32'd0);
        chk("lat_data_hold", bus.flash_data, 32'h12345678);
        send_byte(8'h14, 0);
        chk("lat_done", 32'(done), 32'd1);

        // Oversize error appears the cycle after LEN_HI is accepted.
        pulse_restart();
        send_byte(8'h01, 0);
        chk("ovs_no_err_yet", 32'(error), 32'd0);
        send_byte(8'h02, 0);
        chk("ovs_error", 32'(error), 32'd1);
        chk("ovs_in_ready", 32'(bus.in_ready), 32'd0);
        chk("ovs_core_rst", 32'(core_rst), 32'd1);

        // N = DEPTH exactly is accepted; 2048 bytes of 0x01 sum to 0x00.
        pulse_restart();
        base = mon_addr.size();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        for (int i = 0; i < 2048; i++) send_byte(8'h01, 0);
        send_byte(8'h00, 0);
        repeat (2) @(negedge clk);
        chk("full_nwr", 32'(mon_addr.size() - base), 32'd512);
        if (mon_addr.size() > 0) begin
            chk("full_last_addr", mon_addr[mon_addr.size()-1], 32'h7fc);
            chk("full_last_data", mon_data[mon_data.size()-1], 32'h01010101);
        end
        chk("full_done", 32'(done), 32'd1);
        chk("full_ww", 32'(words_written), 32'd512);

        // Abort mid-word with restart; the byte offered alongside restart is dropped.
        pulse_restart();
        for (int i = 0; i < 8; i++) send_byte(JUMP_OK[8*i +: 8], 0);
        restart      = 1'b1;
        bus.in_data  = 8'h55;
        bus.in_valid = 1'b1;
        @(negedge clk);
        restart      = 1'b0;
        bus.in_valid = 1'b0;
        chk("abort_ww_clear", 32'(words_written), 32'd0);
        chk("abort_core_rst", 32'(core_rst), 32'd1);
        base = mon_addr.size();
        send_jump();
        repeat (3) @(negedge clk);
        expect_jump_writes("abort", base);

        // Same abort using rst; outputs must show reset values while rst is high.
        pulse_restart();
        for (int i = 0; i < 8; i++) send_byte(JUMP_OK[8*i +: 8], 0);
        rst = 1'b1;
        @(negedge clk);
        chk("rstab_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rstab_flash_en", 32'(bus.flash_en), 32'd0);
        chk("rstab_flash_addr", bus.flash_addr, 32'd0);
        chk("rstab_flash_data", bus.flash_data, 32'd0);
        chk("rstab_core_rst", 32'(core_rst), 32'd1);
        chk("rstab_done", 32'(done), 32'd0);
        chk("rstab_error", 32'(error), 32'd0);
        chk("rstab_ww", 32'(words_written), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        base = mon_addr.size();
        send_jump();
        repeat (3) @(negedge clk);
        expect_jump_writes("rstab", base);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
